pc_source_ctrl: RTL and testbench

PC_SOURCE_CTRL -- requirements
Module: pc_source_ctrl

---
 rtl/pc_source_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pc_source_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_source_ctrl.sv
// -----------------------------------------------------------------------------
// pc_source_ctrl
//
// Sequences the program-counter update step of a multi-cycle CPU. A one-cycle
// req pulse arrives when an instruction reaches its PC-update step. The block
// then does one of two things:
//   * a single UPDATE cycle that selects the PC source mux input for the
//     requested kind and loads the PC, or
//   * an exception sequence: save EPC, issue the vector read, wait MEM_LAT
//     cycles for the MDR path, then load the PC from memory.
// All outputs are registered. They are computed on the edge that enters the
// state in which they are valid.
//
// Configuration macro: PC_SOURCE_CTRL_EXC_EN
//   defined   : the exception sequence is built (EXC_* states, EPC/vector
//               strobes, vector address).
//   undefined : exception flags are ignored. Illegal kinds complete as an
//               UPDATE with no PC load. epc_write, mem_read and vec_addr are
//               tied to 0.
//
// Parameters
//   MEM_LAT     memory read latency in cycles (1..15), vector read to MDR valid
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req         one-cycle pulse, accepted only while idle
//   req_kind    0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 RTE, 5..7 illegal
//   exc_opcode  exception flag, sampled with req (highest priority)
//   exc_ovf     exception flag, sampled with req
//   exc_div0    exception flag, sampled with req (lowest priority)
//   pc_src_sel  PC mux select: 0 MDR, 1 ALU result, 2 ALUout, 3 jump, 4 EPC
//   pc_write    PC register load enable
//   epc_write   EPC register load enable
//   mem_read    memory read strobe for the vector fetch
//   vec_addr    exception vector byte address
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse on the last cycle of each accepted request
// -----------------------------------------------------------------------------
module pc_source_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [2:0] req_kind,
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic [2:0] pc_src_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_read,
  output logic [7:0] vec_addr,
  output logic       busy,
  output logic       done
);

  // PC update kinds
  localparam logic [2:0] KIND_SEQ    = 3'd0;
  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_JUMP   = 3'd2;
  localparam logic [2:0] KIND_JR     = 3'd3;
  localparam logic [2:0] KIND_RTE    = 3'd4;

  // PC source mux encodings
  localparam logic [2:0] SEL_MDR    = 3'd0;
  localparam logic [2:0] SEL_ALU    = 3'd1;
  localparam logic [2:0] SEL_ALUOUT = 3'd2;
  localparam logic [2:0] SEL_JUMP   = 3'd3;
  localparam logic [2:0] SEL_EPC    = 3'd4;

  // Select for a legal kind. Illegal kinds never reach a PC load.
  // The select falls back to the reset value for them.
  function automatic logic [2:0] kind_sel(input logic [2:0] kind);
    unique case (kind)
      KIND_SEQ:    kind_sel = SEL_ALU;
      KIND_BRANCH: kind_sel = SEL_ALUOUT;  // not-taken branches arrive as SEQ
      KIND_JUMP:   kind_sel = SEL_JUMP;
      KIND_JR:     kind_sel = SEL_ALU;
      KIND_RTE:    kind_sel = SEL_EPC;
      default:     kind_sel = SEL_ALU;
    endcase
  endfunction

  logic kind_legal;
  assign kind_legal = (req_kind <= KIND_RTE);

`ifdef PC_SOURCE_CTRL_EXC_EN

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    EXC_SAVE,
    EXC_READ,
    EXC_WAIT,
    EXC_LOAD
  } state_t;

  // Vector addresses, in priority order
  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

  // The counter reload is MEM_LAT-1. The final WAIT cycle, when the
  // counter reaches 0, is the edge that enters EXC_LOAD.
  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       exc_take;
  logic [7:0] vec_next;

  // An illegal kind is handled the same way as an opcode exception.
  always_comb begin
    exc_take = exc_opcode | exc_ovf | exc_div0 | ~kind_legal;
    if (exc_opcode || !kind_legal) vec_next = VEC_OPCODE;
    else if (exc_ovf)              vec_next = VEC_OVF;
    else                           vec_next = VEC_DIV0;
  end

  // NOTE: every state and output register below uses non-blocking
  // assignments. Each register then samples the value from before the
  // edge, whatever order the branches of this block are written in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: each register is reset here, including the wait counter. A
      // reset that lands mid-sequence leaves no stale strobe or count.
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      pc_src_sel <= SEL_ALU;
      pc_write   <= 1'b0;
      epc_write  <= 1'b0;
      mem_read   <= 1'b0;
      vec_addr   <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes default low. A state raises a strobe only for its own cycle.
      pc_write  <= 1'b0;
      epc_write <= 1'b0;
      mem_read  <= 1'b0;
      done      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (exc_take) begin
              // An RTE that carries a flag also comes here, so EPC is
              // overwritten.
              state     <= EXC_SAVE;
              epc_write <= 1'b1;
              vec_addr  <= vec_next;
            end else begin
              state      <= UPDATE;
              pc_write   <= 1'b1;
              pc_src_sel <= kind_sel(req_kind);
              done       <= 1'b1;
            end
          end
        end

        UPDATE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        EXC_SAVE: begin
          state    <= EXC_READ;
          mem_read <= 1'b1;
        end

        EXC_READ: begin
          state    <= EXC_WAIT;
          wait_cnt <= WAIT_RELOAD;
        end

        EXC_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state      <= EXC_LOAD;
            pc_write   <= 1'b1;
            pc_src_sel <= SEL_MDR;
            done       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        EXC_LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`else

  typedef enum logic [0:0] {
    IDLE,
    UPDATE
  } state_t;

  state_t state;

  // The exception flags have no effect in this build.
  logic unused_exc_flags;
  assign unused_exc_flags = exc_opcode ^ exc_ovf ^ exc_div0;

  assign epc_write = 1'b0;
  assign mem_read  = 1'b0;
  assign vec_addr  = 8'd0;

  // NOTE: every state and output register below uses non-blocking
  // assignments. Each register then samples the value from before the
  // edge, whatever order the branches of this block are written in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: each register is reset here. A reset that lands mid-update
      // leaves no stale strobe.
      state      <= IDLE;
      pc_src_sel <= SEL_ALU;
      pc_write   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pc_write <= 1'b0;
      done     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req) begin
            state <= UPDATE;
            busy  <= 1'b1;
            done  <= 1'b1;
            // An illegal kind still completes, but it must not load the PC.
            // The select then keeps its previous value.
            if (kind_legal) begin
              pc_write   <= 1'b1;
              pc_src_sel <= kind_sel(req_kind);
            end
          end
        end

        UPDATE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_pc_source_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_source_ctrl
//
// Directed bench for pc_source_ctrl with MEM_LAT = 2. Inputs change on the
// falling edge. Outputs are sampled on the falling edge, or 1 ns after an
// asynchronous reset is asserted. The expected values are worked out by hand
// from the cycle-level behaviour of the controller. The exception-path steps
// are built only when PC_SOURCE_CTRL_EXC_EN is defined, the same as the design.
// -----------------------------------------------------------------------------
module tb_pc_source_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req;
  logic [2:0] req_kind;
  logic       exc_opcode;
  logic       exc_ovf;
  logic       exc_div0;
  logic [2:0] pc_src_sel;
  logic       pc_write;
  logic       epc_write;
  logic       mem_read;
  logic [7:0] vec_addr;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_source_ctrl #(.MEM_LAT(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_kind   (req_kind),
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .pc_src_sel (pc_src_sel),
    .pc_write   (pc_write),
    .epc_write  (epc_write),
    .mem_read   (mem_read),
    .vec_addr   (vec_addr),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Drive a one-cycle req from a falling edge. This returns on the next
  // falling edge, so the caller is in the first cycle after acceptance.
  task automatic issue(input logic [2:0] kind, input logic op, input logic ovf,
                       input logic div0);
    req        = 1'b1;
    req_kind   = kind;
    exc_opcode = op;
    exc_ovf    = ovf;
    exc_div0   = div0;
    @(negedge clk);
    req        = 1'b0;
    exc_opcode = 1'b0;
    exc_ovf    = 1'b0;
    exc_div0   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},  pc_src_sel, 8'd1);
    check({tag, "_pcw"},  pc_write,   8'd0);
    check({tag, "_epcw"}, epc_write,  8'd0);
    check({tag, "_mrd"},  mem_read,   8'd0);
    check({tag, "_vec"},  vec_addr,   8'd0);
    check({tag, "_busy"}, busy,       8'd0);
    check({tag, "_done"}, done,       8'd0);
  endtask

  // Wait a bounded number of cycles for the end of a request. If the bound
  // expires, that is reported as a failed comparison.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, (n < 30) ? 8'd1 : 8'd0, 8'd1);
  endtask

  logic [2:0] kinds [5];
  logic [2:0] sels  [5];

  initial begin
    int cnt;
    reset_n    = 1'b0;
    req        = 1'b0;
    req_kind   = 3'd0;
    exc_opcode = 1'b0;
    exc_ovf    = 1'b0;
    exc_div0   = 1'b0;
    kinds = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2};
    sels  = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd3};

    repeat (2) @(negedge clk);
    check_reset_values("rst");

    // Release reset with req already high. The first rising edge accepts it.
    reset_n = 1'b1;
    issue(3'd2, 1'b0, 1'b0, 1'b0);
    check("jump_sel",  pc_src_sel, 8'd3);
    check("jump_pcw",  pc_write,   8'd1);
    check("jump_done", done,       8'd1);
    check("jump_busy", busy,       8'd1);
    check("jump_epcw", epc_write,  8'd0);
    @(negedge clk);
    check("jump_busy_after", busy,       8'd0);
    check("jump_pcw_after",  pc_write,   8'd0);
    check("jump_done_after", done,       8'd0);
    check("jump_sel_hold",   pc_src_sel, 8'd3);

    // Each legal kind and its mux select
    for (int i = 0; i < 5; i++) begin
      issue(kinds[i], 1'b0, 1'b0, 1'b0);
      check($sformatf("kind%0d_sel", kinds[i]), pc_src_sel, 8'(sels[i]));
      check($sformatf("kind%0d_pcw", kinds[i]), pc_write,   8'd1);
      check($sformatf("kind%0d_done", kinds[i]), done,      8'd1);
      @(negedge clk);
      check($sformatf("kind%0d_idle", kinds[i]), busy,      8'd0);
    end

    // A req during the UPDATE cycle is ignored.
    issue(3'd4, 1'b0, 1'b0, 1'b0);
    check("busyreq_sel", pc_src_sel, 8'd4);
    issue(3'd2, 1'b0, 1'b0, 1'b0);
    check("busyreq_pcw",  pc_write,   8'd0);
    check("busyreq_done", done,       8'd0);
    check("busyreq_busy", busy,       8'd0);
    check("busyreq_sel2", pc_src_sel, 8'd4);

    // Reset in the UPDATE cycle clears everything at once.
    issue(3'd2, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_upd");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifndef PC_SOURCE_CTRL_EXC_EN
    // Exception flags are ignored. Illegal kinds complete without a PC load.
    issue(3'd1, 1'b0, 1'b1, 1'b1);
    check("noexc_flag_sel",  pc_src_sel, 8'd2);
    check("noexc_flag_pcw",  pc_write,   8'd1);
    check("noexc_flag_epcw", epc_write,  8'd0);
    @(negedge clk);
    issue(3'd7, 1'b0, 1'b0, 1'b0);
    check("ill7_done", done,       8'd1);
    check("ill7_pcw",  pc_write,   8'd0);
    check("ill7_epcw", epc_write,  8'd0);
    check("ill7_mrd",  mem_read,   8'd0);
    check("ill7_vec",  vec_addr,   8'd0);
    check("ill7_sel",  pc_src_sel, 8'd2);
    @(negedge clk);
    check("ill7_idle", busy, 8'd0);
`else
    // Overflow exception, MEM_LAT = 2, with the sequence checked cycle by cycle
    issue(3'd0, 1'b0, 1'b1, 1'b0);
    check("ovf_t1_epcw", epc_write, 8'd1);
    check("ovf_t1_pcw",  pc_write,  8'd0);
    check("ovf_t1_busy", busy,      8'd1);
    check("ovf_t1_done", done,      8'd0);
    @(negedge clk);
    check("ovf_t2_mrd",  mem_read,  8'd1);
    check("ovf_t2_vec",  vec_addr,  8'd254);
    check("ovf_t2_epcw", epc_write, 8'd0);
    @(negedge clk);
    check("ovf_t3_mrd",  mem_read,  8'd0);
    check("ovf_t3_pcw",  pc_write,  8'd0);
    check("ovf_t3_busy", busy,      8'd1);
    @(negedge clk);
    check("ovf_t4_pcw",  pc_write,  8'd0);
    check("ovf_t4_done", done,      8'd0);
    @(negedge clk);
    check("ovf_t5_pcw",  pc_write,   8'd1);
    check("ovf_t5_sel",  pc_src_sel, 8'd0);
    check("ovf_t5_done", done,       8'd1);
    check("ovf_t5_vec",  vec_addr,   8'd254);
    @(negedge clk);
    check("ovf_t6_busy", busy,       8'd0);
    check("ovf_t6_sel",  pc_src_sel, 8'd0);

    // Priority: ovf over div0, illegal kind as opcode, div0 alone
    issue(3'd0, 1'b0, 1'b1, 1'b1);
    check("prio_ovf_div0", vec_addr, 8'd254);
    wait_idle("prio_ovf_div0");
    issue(3'd6, 1'b0, 1'b0, 1'b0);
    check("prio_kind6", vec_addr, 8'd253);
    wait_idle("prio_kind6");
    issue(3'd1, 1'b1, 1'b1, 1'b1);
    check("prio_opcode", vec_addr, 8'd253);
    wait_idle("prio_opcode");

    // RTE with a flag takes the exception path and writes EPC.
    issue(3'd4, 1'b0, 1'b0, 1'b1);
    check("rte_exc_epcw", epc_write, 8'd1);
    check("rte_exc_pcw",  pc_write,  8'd0);
    check("rte_exc_vec",  vec_addr,  8'd255);
    wait_idle("rte_exc");

    // A second req during the sequence is ignored, so there is a single done.
    issue(3'd0, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    @(negedge clk);
    issue(3'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    check("ignored_req_done_count", 8'(cnt), 8'd1);
    check("ignored_req_sel", pc_src_sel, 8'd0);

    // Reset during EXC_WAIT aborts the sequence, and no PC load follows.
    issue(3'd0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_in_wait_busy", busy, 8'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pc_write !== 1'b0 || done !== 1'b0) cnt++;
    end
    check("abort_no_strobes", 8'(cnt), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
